frame_addr2xybel: RTL and testbench

Inverse of the XY/Bel-to-FAR mapper. The block takes a configuration frame address, a word offset and an msb/lsb select, and recovers the packed CLB LUT location `{X, Y, Bel}`. It sits on the readback and verification path: a FAR/word pair produced for a LUT rewrite is decoded back to the site it targets, so software can cross-check it. It uses a multi-cycle FSM with a Start/Done handshake.

---
 rtl/far_map_pkg.sv | 59 +++++
 rtl/frame_addr2xybel_if.sv | 21 ++
 rtl/far_major2x.sv | 27 ++
 rtl/frame_addr2xybel.sv | 260 ++++++++++++++++++++++++++
 tb/tb_frame_addr2xybel.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/far_map_pkg.sv
// Shared definitions for the FAR-to-{X,Y,Bel} decoder: FAR/XYBel field layout,
// FSM state encoding, the Major-column region table and the LUT Minor constants.
package far_map_pkg;

    localparam int FAR_MINOR_LSB = 0;
    localparam int FAR_MINOR_W   = 7;
    localparam int FAR_MAJOR_LSB = 7;
    localparam int FAR_MAJOR_W   = 10;
    localparam int FAR_HCLK_LSB  = 17;
    localparam int FAR_HCLK_W    = 5;
    localparam int FAR_TOP_BIT   = 22;
    localparam int FAR_BTYPE_LSB = 23;
    localparam int FAR_BTYPE_W   = 3;
    localparam int FAR_PAD_LSB   = 26;
    localparam int FAR_PAD_W     = 6;

    localparam int XYB_BEL_W = 2;
    localparam int XYB_Y_W   = 15;
    localparam int XYB_X_W   = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_COLUMN = 3'd2,
        ST_ROW    = 3'd3,
        ST_DONE   = 3'd4
    } far_state_e;

    typedef struct packed {
        logic [9:0] lo;
        logic [9:0] hi;
        logic [3:0] k;
    } far_region_t;

    // Regions are sorted by lower bound; k counts the non-CLB columns below each region.
    localparam int NUM_REGIONS = 8;
    localparam far_region_t REGION_TBL [NUM_REGIONS] = '{
        '{lo: 10'd2,  hi: 10'd5,  k: 4'd2},
        '{lo: 10'd7,  hi: 10'd16, k: 4'd3},
        '{lo: 10'd18, hi: 10'd19, k: 4'd4},
        '{lo: 10'd21, hi: 10'd28, k: 4'd5},
        '{lo: 10'd30, hi: 10'd41, k: 4'd6},
        '{lo: 10'd43, hi: 10'd52, k: 4'd7},
        '{lo: 10'd54, hi: 10'd57, k: 4'd8},
        '{lo: 10'd59, hi: 10'd62, k: 4'd9}
    };

    localparam logic [6:0] MINOR_X0 = 7'd32;
    localparam logic [6:0] MINOR_X1 = 7'd26;

    function automatic logic [31:0] pack_xybel(
        input logic [XYB_X_W-1:0]   x,
        input logic [XYB_Y_W-1:0]   y,
        input logic [XYB_BEL_W-1:0] bel
    );
        return {x, y, bel};
    endfunction

endpackage

// File: rtl/frame_addr2xybel_if.sv
// Request/response bundle between a FAR decode requester (master) and frame_addr2xybel (slave).
interface frame_addr2xybel_if;
    logic        Start;
    logic [31:0] Frame_address;
    logic [7:0]  word_offset;
    logic        msb_lsb;
    logic [31:0] XYBel;
    logic        Busy;
    logic        done_XY;
    logic        Error;

    modport master (
        output Start, Frame_address, word_offset, msb_lsb,
        input  XYBel, Busy, done_XY, Error
    );

    modport slave (
        input  Start, Frame_address, word_offset, msb_lsb,
        output XYBel, Busy, done_XY, Error
    );
endinterface

// File: rtl/far_major2x.sv
// Combinational Major -> X[14:1] lookup: picks the highest region whose lower
// bound does not exceed Major and flags whether Major really lies inside it.
module far_major2x
    import far_map_pkg::*;
(
    input  logic [9:0]  major,
    output logic [13:0] x_hi,
    output logic        hit
);

    logic [2:0] sel_s;
    logic       found_s;

    // Scan the sorted table; the last region whose lower bound is met wins.
    always_comb begin
        sel_s   = 3'd0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            sel_s   = (major >= REGION_TBL[i].lo) ? 3'(i) : sel_s;
            found_s = found_s | (major >= REGION_TBL[i].lo);
        end
    end

    assign x_hi = {4'd0, major} - {10'd0, REGION_TBL[sel_s].k};
    assign hit  = found_s & (major <= REGION_TBL[sel_s].hi);

endmodule

// File: rtl/frame_addr2xybel.sv
// Decodes a configuration frame address + word offset back into the packed CLB
// LUT site {X, Y, Bel}. Validity checks and early exits are built only with FAR2XY_CHECK_EN.
module frame_addr2xybel
    import far_map_pkg::*;
#(
    parameter int Max_Y      = 150,
    parameter int Y_Half     = 50,
    parameter int Coloumn_HT = 50,
    parameter int Col_Half   = 25
) (
    input  logic              Clk,
    input  logic              Reset_n,
    frame_addr2xybel_if.slave bus
);

`ifdef FAR2XY_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [4:0]  HCLK_LIM_BOT = 5'((Max_Y - Y_Half) / Coloumn_HT);
    localparam logic [4:0]  HCLK_LIM_TOP = 5'(Y_Half / Coloumn_HT);
    localparam logic [7:0]  WO_SPLIT     = 8'(2 * Col_Half);
    localparam logic [7:0]  WO_MAX       = 8'(4 * Col_Half + 1);
    localparam logic [14:0] ROW_STEP     = 15'(Coloumn_HT);
    localparam logic [14:0] Y_BASE_BOT   = 15'(Y_Half);
    localparam logic [14:0] Y_BASE_TOP   = 15'(Y_Half - 1);

    far_state_e  state_r, state_nx_s;

    logic [31:0] far_r;
    logic [7:0]  wo_r;
    logic        msb_r;
    logic [14:0] yo_r;
    logic [14:0] acc_r;
    logic        bel1_r;
    logic        x0_r;
    logic [13:0] xhi_r;
    logic [4:0]  cnt_r;
    logic        err_r;

    logic [31:0] xybel_r, xybel_nx_s;
    logic        busy_r, busy_nx_s;
    logic        done_r, done_nx_s;
    logic        error_r, error_nx_s;

    logic [FAR_PAD_W-1:0]   pad_s;
    logic [FAR_BTYPE_W-1:0] btype_s;
    logic                   top_s;
    logic [FAR_HCLK_W-1:0]  hclk_s;
    logic [FAR_MAJOR_W-1:0] major_s;
    logic [FAR_MINOR_W-1:0] minor_s;

    logic        wo_hi_s, wo_odd_s, bel1_s;
    logic [7:0]  wo_adj_s;
    logic [14:0] yo_s;
    logic        wo_err_s, minor_err_s, hclk_err_s, decode_err_s, x0_s;
    logic [13:0] xhi_s;
    logic        hit_s, column_err_s;
    logic [14:0] sum_s, y_s;

    assign pad_s   = far_r[FAR_PAD_LSB   +: FAR_PAD_W];
    assign btype_s = far_r[FAR_BTYPE_LSB +: FAR_BTYPE_W];
    assign top_s   = far_r[FAR_TOP_BIT];
    assign hclk_s  = far_r[FAR_HCLK_LSB  +: FAR_HCLK_W];
    assign major_s = far_r[FAR_MAJOR_LSB +: FAR_MAJOR_W];
    assign minor_s = far_r[FAR_MINOR_LSB +: FAR_MINOR_W];

    // Word groups: at or below the split, odd words are Bel[1]=0; above it the parity flips.
    assign wo_hi_s  = (wo_r > WO_SPLIT);
    assign wo_odd_s = wo_r[0];
    assign bel1_s   = wo_hi_s ? wo_odd_s : ~wo_odd_s;

    // Remove the per-group word bias before halving into the row offset.
    always_comb begin
        case ({wo_hi_s, wo_odd_s})
            2'b01:   wo_adj_s = wo_r - 8'd1;
            2'b11:   wo_adj_s = wo_r - 8'd3;
            default: wo_adj_s = wo_r - 8'd2;
        endcase
    end

    assign yo_s = {7'd0, wo_adj_s} >> 1;

    assign wo_err_s    = (wo_r == 8'd0) || (wo_r == (WO_SPLIT + 8'd1)) || (wo_r > WO_MAX);
    assign minor_err_s = (minor_s != MINOR_X0) && (minor_s != MINOR_X1);
    assign x0_s        = (minor_s == MINOR_X1);
    assign hclk_err_s  = top_s ? (hclk_s >= HCLK_LIM_TOP) : (hclk_s >= HCLK_LIM_BOT);

    assign decode_err_s = CHECK_EN & ((pad_s != 6'd0) | (btype_s != 3'd0) |
                                      minor_err_s | wo_err_s | hclk_err_s);

    far_major2x u_major2x (
        .major (major_s),
        .x_hi  (xhi_s),
        .hit   (hit_s)
    );

    assign column_err_s = CHECK_EN & ~hit_s;

    // Top half counts rows downward from the boundary, bottom half upward.
    always_comb begin
        sum_s = acc_r + yo_r;
        if (top_s) begin
            y_s = Y_BASE_TOP - sum_s;
        end else begin
            y_s = Y_BASE_BOT + sum_s;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (decode_err_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_COLUMN;
                end
            end
            ST_COLUMN: begin
                if (column_err_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ROW;
                end
            end
            ST_ROW: begin
                if (cnt_r == 5'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ROW;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output next-values: Busy rises at accept, results and done land as DONE retires.
    always_comb begin
        xybel_nx_s = xybel_r;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        error_nx_s = error_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    busy_nx_s  = 1'b1;
                    error_nx_s = 1'b0;
                end else begin
                    busy_nx_s  = busy_r;
                end
            end
            ST_DONE: begin
                busy_nx_s  = 1'b0;
                done_nx_s  = 1'b1;
                error_nx_s = err_r;
                if (err_r) begin
                    xybel_nx_s = 32'd0;
                end else begin
                    xybel_nx_s = pack_xybel({xhi_r, x0_r}, y_s, {bel1_r, msb_r});
                end
            end
            default: begin
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            xybel_r <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            xybel_r <= xybel_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
            error_r <= error_nx_s;
        end
    end

    // Datapath: capture on accept, then decode, column lookup and row accumulation.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            far_r  <= 32'd0;
            wo_r   <= 8'd0;
            msb_r  <= 1'b0;
            yo_r   <= 15'd0;
            acc_r  <= 15'd0;
            bel1_r <= 1'b0;
            x0_r   <= 1'b0;
            xhi_r  <= 14'd0;
            cnt_r  <= 5'd0;
            err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.Start) begin
                        far_r <= bus.Frame_address;
                        wo_r  <= bus.word_offset;
                        msb_r <= bus.msb_lsb;
                    end else begin
                        far_r <= far_r;
                    end
                end
                ST_DECODE: begin
                    yo_r   <= yo_s;
                    bel1_r <= bel1_s;
                    x0_r   <= x0_s;
                    cnt_r  <= hclk_s;
                    acc_r  <= 15'd0;
                    err_r  <= decode_err_s;
                end
                ST_COLUMN: begin
                    xhi_r <= xhi_s;
                    err_r <= column_err_s;
                end
                ST_ROW: begin
                    if (cnt_r != 5'd0) begin
                        acc_r <= acc_r + ROW_STEP;
                        cnt_r <= cnt_r - 5'd1;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    assign bus.XYBel   = xybel_r;
    assign bus.Busy    = busy_r;
    assign bus.done_XY = done_r;
    assign bus.Error   = error_r;

endmodule

// File: tb/tb_frame_addr2xybel.sv
// Directed scoreboard bench for frame_addr2xybel; expectations follow FAR2XY_CHECK_EN.
module tb_frame_addr2xybel;

`ifdef FAR2XY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] xybel;
        logic        err;
        logic [7:0]  lat;
        logic        chk_xy;
    } exp_t;

    logic Clk;
    logic Reset_n;
    int   n_total;
    int   n_pass;
    int   n_fail;
    exp_t sb_q[$];

    frame_addr2xybel_if bus ();

    frame_addr2xybel dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] far, input logic [7:0] wo, input logic msb,
                         input logic [31:0] exy, input logic eerr, input logic [7:0] elat,
                         input logic chk_xy);
        exp_t e;
        bus.Frame_address = far;
        bus.word_offset   = wo;
        bus.msb_lsb       = msb;
        bus.Start         = 1'b1;
        e.xybel  = exy;
        e.err    = eerr;
        e.lat    = elat;
        e.chk_xy = chk_xy;
        sb_q.push_back(e);
    endtask

    task automatic accept_edge(input string tag);
        @(posedge Clk);
        #1;
        check({tag, "_busy_at_accept"}, 32'(bus.Busy), 32'd1);
        check({tag, "_error_cleared"}, 32'(bus.Error), 32'd0);
    endtask

    task automatic finish_run(input string tag, input bit hold);
        exp_t e;
        int   lat;
        lat = 0;
        if (!hold) bus.Start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk);
            #1;
            if (bus.done_XY) begin
                lat = c;
                break;
            end
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = {32'd0, 1'b1, 8'hFF, 1'b1};
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_error"}, 32'(bus.Error), 32'(e.err));
        check({tag, "_busy_at_done"}, 32'(bus.Busy), 32'd0);
        if (e.chk_xy) check({tag, "_xybel"}, bus.XYBel, e.xybel);
        if (!hold) begin
            @(posedge Clk);
            #1;
            check({tag, "_done_pulse"}, 32'(bus.done_XY), 32'd0);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        Reset_n = 1'b0;
        bus.Start = 1'b0;
        bus.Frame_address = 32'd0;
        bus.word_offset = 8'd0;
        bus.msb_lsb = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_xybel", bus.XYBel, 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        check("reset_done", 32'(bus.done_XY), 32'd0);
        check("reset_error", 32'(bus.Error), 32'd0);
        Reset_n = 1'b1;

        drive(32'h0000_0420, 8'd21, 1'b1, 32'h0014_00F1, 1'b0, 8'd4, 1'b1);
        accept_edge("x10y60");
        finish_run("x10y60", 1'b0);

        drive(32'h0002_159A, 8'd63, 1'b0, 32'h0092_020A, 1'b0, 8'd5, 1'b1);
        accept_edge("x73y130");
        finish_run("x73y130", 1'b0);

        drive(32'h0040_0120, 8'd2, 1'b1, 32'h0000_00C7, 1'b0, 8'd4, 1'b1);
        accept_edge("x0y49");
        finish_run("x0y49", 1'b0);

        // Major 6 sits in a gap; Start stays high so the next run follows one IDLE cycle later.
        drive(32'h0000_0320, 8'd1, 1'b0, 32'd0, CHK, CHK ? 8'd3 : 8'd4, CHK);
        accept_edge("major_gap");
        finish_run("major_gap", 1'b1);

        drive(32'h0002_1F1A, 8'd101, 1'b1, 32'h00D6_0257, 1'b0, 8'd5, 1'b1);
        accept_edge("b2b_wo101");
        finish_run("b2b_wo101", 1'b0);

        drive(32'h0000_041B, 8'd21, 1'b1, 32'd0, CHK, CHK ? 8'd2 : 8'd4, CHK);
        accept_edge("minor27");
        finish_run("minor27", 1'b0);

        drive(32'h0000_0420, 8'd51, 1'b1, 32'd0, CHK, CHK ? 8'd2 : 8'd4, CHK);
        accept_edge("wo51");
        finish_run("wo51", 1'b0);

        drive(32'h0042_0420, 8'd21, 1'b0, 32'd0, CHK, CHK ? 8'd2 : 8'd5, CHK);
        accept_edge("hclk_top_lim");
        finish_run("hclk_top_lim", 1'b0);

        drive(32'h0080_0420, 8'd21, 1'b0, 32'd0, CHK, CHK ? 8'd2 : 8'd4, CHK);
        accept_edge("block_type");
        finish_run("block_type", 1'b0);

        drive(32'h0040_0120, 8'd100, 1'b1, 32'h0000_0001, 1'b0, 8'd4, 1'b1);
        accept_edge("wo100_y0");
        finish_run("wo100_y0", 1'b0);

        // Abort the HCLK=1 vector in ROW; the same request is re-accepted once reset lifts.
        drive(32'h0002_159A, 8'd63, 1'b0, 32'h0092_020A, 1'b0, 8'd5, 1'b1);
        accept_edge("rst_abort");
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_mid_xybel", bus.XYBel, 32'd0);
        check("rst_mid_busy", 32'(bus.Busy), 32'd0);
        check("rst_mid_done", 32'(bus.done_XY), 32'd0);
        check("rst_mid_error", 32'(bus.Error), 32'd0);
        Reset_n = 1'b1;
        accept_edge("rst_rerun");
        finish_run("rst_rerun", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
